gf_col_mult_seq: RTL

Sequential, parametrised GF(2^M) constant-multiplier column for the BCH Euclidean datapath. It accepts one field element `b`, then streams the products P_j = b·α^(COL·j) for j = 1..NUM_OUT, delivering LANES products per beat over a valid/ready interface. It replaces the fixed 13-bit, 16-output combinational columns: field width, column index, product count and lane count are parameters, and output backpressure is supported. It sits between the syndrome/key-equation register file and the Chien/Euclidean update stages.

---
 rtl/gf_col_mult_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/gf_col_mult_seq.sv
// Sequential GF(2^M) constant-multiplier column: one input b yields NUM_OUT products
// b*alpha^(COL*j), LANES per beat over valid/ready. Optional lane parity: GFCOL_PARITY_EN.
module gf_col_mult_seq #(
    parameter int            M       = 13,
    parameter logic [M-1:0]  POLY    = 13'h001B,
    parameter int            COL     = 5,
    parameter int            NUM_OUT = 16,
    parameter int            LANES   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [M-1:0]         b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*M-1:0]   out_data,
    output logic                 out_last
`ifdef GFCOL_PARITY_EN
    ,
    output logic [LANES-1:0]     out_par
`endif
);

    localparam int BEATS = NUM_OUT / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if ((NUM_OUT % LANES) != 0) begin : g_bad_cfg
        $error("gf_col_mult_seq: NUM_OUT must be a multiple of LANES");
    end

    function automatic logic [M-1:0] mul_alpha(input logic [M-1:0] x);
        mul_alpha = {x[M-2:0], 1'b0} ^ (x[M-1] ? POLY : {M{1'b0}});
    endfunction

    // Column i of the matrix is alpha^(i+e); evaluated only on constants.
    function automatic logic [M*M-1:0] build_mat(input int e);
        logic [M-1:0] v;
        build_mat = '0;
        for (int i = 0; i < M; i++) begin
            v    = '0;
            v[i] = 1'b1;
            for (int n = 0; n < e; n++) begin
                v = mul_alpha(v);
            end
            build_mat[i*M +: M] = v;
        end
    endfunction

    function automatic logic [M-1:0] mat_apply(input logic [M*M-1:0] mat, input logic [M-1:0] x);
        mat_apply = '0;
        for (int i = 0; i < M; i++) begin
            mat_apply = mat_apply ^ (mat[i*M +: M] & {M{x[i]}});
        end
    endfunction

    function automatic logic lane_parity(input logic [M-1:0] x);
        lane_parity = ^x;
    endfunction

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [M*M-1:0] STEP_MAT = build_mat(COL * LANES);

    state_t                  state_r;
    logic [BW-1:0]           beat_r;
    logic [LANES-1:0][M-1:0] lane_r;
    logic [LANES-1:0][M-1:0] init_s;
    logic [LANES-1:0][M-1:0] step_s;
    logic [LANES-1:0]        init_par_s;
    logic [LANES-1:0]        step_par_s;
    logic [LANES-1:0]        par_r;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam logic [M*M-1:0] INIT_MAT = build_mat(COL * (k + 1));
        assign init_s[k]     = mat_apply(INIT_MAT, b);
        assign step_s[k]     = mat_apply(STEP_MAT, lane_r[k]);
        assign init_par_s[k] = lane_parity(init_s[k]);
        assign step_par_s[k] = lane_parity(step_s[k]);
    end

    assign out_data = lane_r;

`ifdef GFCOL_PARITY_EN
    assign out_par = par_r;
`endif

    // Control FSM with registered handshake outputs, lane and parity registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            beat_r    <= '0;
            lane_r    <= '0;
            par_r     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        state_r   <= RUN;
                        lane_r    <= init_s;
                        par_r     <= init_par_s;
                        beat_r    <= '0;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        out_last  <= (BEATS == 1);
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            // Lanes keep the final beat; only the handshake drops.
                            state_r   <= IDLE;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            lane_r    <= step_s;
                            par_r     <= step_par_s;
                            beat_r    <= beat_r + BW'(1);
                            out_last  <= (beat_r == BW'(BEATS - 2));
                        end
                    end else begin
                        state_r   <= RUN;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    beat_r    <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

`ifndef GFCOL_PARITY_EN
    logic unused_par_s;
    assign unused_par_s = ^par_r;
`endif

endmodule
